// File: rtl/psram_bist.sv
// psram_bist: pattern write / read-back / compare self-test engine for the PSRAM HS controller user port.
module psram_bist #(
    parameter int ADDR_W      = 21,
    parameter int DATA_W      = 64,
    parameter int BURST_BEATS = 4,
    parameter int NUM_BURSTS  = 16,
    parameter int ADDR_STEP   = 16,
    parameter int CMD_GAP     = 14,
    parameter int RD_TIMEOUT  = 255
) (
    input  logic              ext_clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic              i_loop,
    input  logic [1:0]        i_mode,
    input  logic [31:0]       i_seed,
    input  logic [ADDR_W-1:0] i_base_addr,
    input  logic              i_init_calib,
    output logic              o_cmd,
    output logic              o_cmd_en,
    output logic [ADDR_W-1:0] o_addr,
    output logic [DATA_W-1:0] o_wr_data,
    input  logic [DATA_W-1:0] i_rd_data,
    input  logic              i_rd_data_valid,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_pass,
    output logic [15:0]       o_err_count,
    output logic [ADDR_W-1:0] o_first_err_addr,
    output logic [7:0]        o_first_err_beat,
    output logic              o_timeout,
    output logic [15:0]       o_pass_count
);
    typedef enum logic [3:0] {IDLE, WAIT_CALIB, WR_CMD, WR_BEATS, WR_GAP,
                              RD_CMD, RD_WAIT, RD_BEATS, RD_GAP, DONE} state_t;
    localparam logic [15:0] LAST_BEAT  = 16'(BURST_BEATS - 1);
    localparam logic [15:0] ALL_BEATS  = 16'(BURST_BEATS);
    localparam logic [15:0] LAST_BURST = 16'(NUM_BURSTS - 1);
    localparam logic [15:0] GAP_END    = 16'(CMD_GAP - 1);
    localparam logic [15:0] TMO_END    = 16'(RD_TIMEOUT - 1);

    state_t              r_state, w_next;
    logic [15:0]         r_b, r_k, r_cnt, r_err, r_pass_count;
    logic [31:0]         r_lfsr;
    logic                r_cmp_mis, r_have_err, r_done, r_pass, r_timeout;
    logic [7:0]          r_cmp_beat, r_miss, r_first_beat;
    logic [ADDR_W-1:0]   r_cmp_addr, r_first_addr;
    logic [31:0]         w_g, w_seed, w_lfsr_nx;
    logic [ADDR_W-1:0]   w_addr;
    logic [DATA_W-1:0]   w_lfsr_pat, w_pat;
    logic [16:0]         w_err_sum;
    logic [15:0]         w_err_next;

    assign w_g        = 32'(r_b) * 32'(BURST_BEATS) + 32'(r_k);
    assign w_seed     = (i_seed == 32'd0) ? 32'd1 : i_seed;
    assign w_lfsr_nx  = r_lfsr[0] ? ((r_lfsr >> 1) ^ 32'h80200003) : (r_lfsr >> 1);
    assign w_addr     = i_base_addr + ADDR_W'(32'(r_b) * 32'(ADDR_STEP));
    assign w_err_sum  = {1'b0, r_err} + 17'(r_cmp_mis) + 17'(r_miss);
    assign w_err_next = w_err_sum[16] ? 16'hFFFF : w_err_sum[15:0];

    always_comb begin
        w_lfsr_pat = '0;
        for (int i = 0; i < DATA_W / 32; i++)
            w_lfsr_pat[DATA_W-1-32*i -: 32] = i[0] ? ~r_lfsr : r_lfsr;
    end

    always_comb begin
        w_pat = (i_mode == 2'd0) ? {DATA_W/32{r_b, r_k}} :
                (i_mode == 2'd1) ? w_lfsr_pat :
                (i_mode == 2'd2) ? (DATA_W'(1) << (w_g % DATA_W)) :
                (w_g[0] ? {DATA_W/2{2'b10}} : {DATA_W/2{2'b01}});
    end

    always_ff @(posedge ext_clk or negedge rst_n)
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:       w_next = i_start ? WAIT_CALIB : IDLE;
            WAIT_CALIB: w_next = i_init_calib ? WR_CMD : WAIT_CALIB;
            WR_CMD:     w_next = (BURST_BEATS == 1) ? WR_GAP : WR_BEATS;
            WR_BEATS:   w_next = (r_k == LAST_BEAT) ? WR_GAP : WR_BEATS;
            WR_GAP:     w_next = (r_cnt != GAP_END) ? WR_GAP : (r_b == LAST_BURST) ? RD_CMD : WR_CMD;
            RD_CMD:     w_next = RD_WAIT;
            RD_WAIT:    w_next = i_rd_data_valid ? ((BURST_BEATS == 1) ? RD_GAP : RD_BEATS) :
                                 (r_cnt == TMO_END) ? RD_GAP : RD_WAIT;
            RD_BEATS:   w_next = (!i_rd_data_valid || r_k == LAST_BEAT) ? RD_GAP : RD_BEATS;
            RD_GAP:     w_next = (r_cnt < GAP_END || r_k != ALL_BEATS) ? RD_GAP :
                                 (r_b == LAST_BURST) ? DONE : RD_CMD;
            DONE:       w_next = i_loop ? WAIT_CALIB : IDLE;
            default:    w_next = IDLE;
        endcase
    end

    always_comb begin
        o_cmd_en  = (r_state == WR_CMD) || (r_state == RD_CMD);
        o_cmd     = r_state == WR_CMD;
        o_addr    = ((r_state == WR_CMD) || (r_state == RD_CMD)) ? w_addr : '0;
        o_wr_data = ((r_state == WR_CMD) || (r_state == WR_BEATS)) ? w_pat : '0;
        o_busy    = r_state != IDLE;
    end

    always_ff @(posedge ext_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_b <= '0; r_k <= '0; r_cnt <= '0; r_err <= '0; r_pass_count <= '0;
            r_lfsr <= 32'h1; r_cmp_mis <= 1'b0; r_have_err <= 1'b0; r_done <= 1'b0;
            r_pass <= 1'b0; r_timeout <= 1'b0; r_cmp_beat <= '0; r_miss <= '0;
            r_first_beat <= '0; r_cmp_addr <= '0; r_first_addr <= '0;
        end else begin
            r_cmp_mis <= 1'b0;
            r_miss    <= '0;
            r_cnt     <= (r_state == w_next) ? r_cnt + 16'd1 : 16'd0;
            r_err     <= w_err_next;
            if (r_cmp_mis && !r_have_err) begin
                r_have_err   <= 1'b1;
                r_first_addr <= r_cmp_addr;
                r_first_beat <= r_cmp_beat;
            end
            case (r_state)
                IDLE: if (i_start) begin
                    r_b <= '0; r_k <= '0; r_lfsr <= w_seed; r_err <= '0; r_have_err <= 1'b0;
                    r_first_addr <= '0; r_first_beat <= '0; r_timeout <= 1'b0;
                    r_done <= 1'b0; r_pass <= 1'b0;
                end
                WR_CMD, WR_BEATS: begin
                    r_lfsr <= w_lfsr_nx;
                    r_k    <= r_k + 16'd1;
                end
                WR_GAP: if (w_next != WR_GAP) begin
                    r_k <= '0;
                    r_b <= (w_next == RD_CMD) ? 16'd0 : r_b + 16'd1;
                    if (w_next == RD_CMD) r_lfsr <= w_seed;
                end
                RD_WAIT, RD_BEATS: begin
                    if (i_rd_data_valid) begin
                        r_cmp_mis  <= i_rd_data != w_pat;
                        r_cmp_beat <= r_k[7:0];
                        r_cmp_addr <= w_addr;
                        r_lfsr     <= w_lfsr_nx;
                        r_k        <= r_k + 16'd1;
                    end else if (r_state == RD_BEATS) begin
                        r_miss <= 8'(BURST_BEATS) - r_k[7:0];
                    end else if (w_next == RD_GAP) begin
                        r_timeout <= 1'b1;
                    end
                end
                // Beats never received still advance the LFSR so later bursts stay aligned.
                RD_GAP: begin
                    if (r_k != ALL_BEATS) begin
                        r_lfsr <= w_lfsr_nx;
                        r_k    <= r_k + 16'd1;
                    end else if (w_next == RD_CMD) begin
                        r_k <= '0;
                        r_b <= r_b + 16'd1;
                    end
                end
                DONE: begin
                    r_pass_count <= r_pass_count + 16'd1;
                    r_b <= '0; r_k <= '0; r_lfsr <= w_seed;
                    if (!i_loop) begin
                        r_done <= 1'b1;
                        r_pass <= (r_err == 16'd0) && !r_timeout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_done           = r_done;
    assign o_pass           = r_pass;
    assign o_err_count      = r_err;
    assign o_first_err_addr = r_first_addr;
    assign o_first_err_beat = r_first_beat;
    assign o_timeout        = r_timeout;
    assign o_pass_count     = r_pass_count;
endmodule

// File: tb/tb_psram_bist.sv
// tb_psram_bist: directed/randomized run of psram_bist against a PSRAM controller model with pattern reference.
module tb_psram_bist;
    localparam int AW = 21, DW = 64, BB = 4, NB = 16, STEP = 16, LAT = 14;

    logic          ext_clk = 1'b0, rst_n = 1'b0;
    logic          i_start = 1'b0, i_loop = 1'b0, i_init_calib = 1'b0;
    logic [1:0]    i_mode = '0;
    logic [31:0]   i_seed = '0;
    logic [AW-1:0] i_base_addr = '0;
    logic [DW-1:0] i_rd_data = '0;
    logic          i_rd_data_valid = 1'b0;
    logic          o_cmd, o_cmd_en, o_busy, o_done, o_pass, o_timeout;
    logic [AW-1:0] o_addr, o_first_err_addr;
    logic [DW-1:0] o_wr_data;
    logic [15:0]   o_err_count, o_pass_count;
    logic [7:0]    o_first_err_beat;

    psram_bist dut (
        .ext_clk(ext_clk), .rst_n(rst_n), .i_start(i_start), .i_loop(i_loop),
        .i_mode(i_mode), .i_seed(i_seed), .i_base_addr(i_base_addr),
        .i_init_calib(i_init_calib), .o_cmd(o_cmd), .o_cmd_en(o_cmd_en),
        .o_addr(o_addr), .o_wr_data(o_wr_data), .i_rd_data(i_rd_data),
        .i_rd_data_valid(i_rd_data_valid), .o_busy(o_busy), .o_done(o_done),
        .o_pass(o_pass), .o_err_count(o_err_count), .o_first_err_addr(o_first_err_addr),
        .o_first_err_beat(o_first_err_beat), .o_timeout(o_timeout), .o_pass_count(o_pass_count)
    );

    always #5 ext_clk = ~ext_clk;

    int total = 0, bad = 0;
    int wcnt = 0, rcnt = 0, cyc = 0, nocal_cmd = 0;
    bit f_corrupt = 0, f_novalid = 0, f_short = 0;
    logic [31:0]   t_seed = '0;
    logic [1:0]    t_mode = '0;
    logic [AW-1:0] t_base = '0;
    logic [DW-1:0] mem [int];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_at(input logic [31:0] s, input int g);
        logic [31:0] l = (s == 32'd0) ? 32'd1 : s;
        for (int i = 0; i < g; i++) l = l[0] ? ((l >> 1) ^ 32'h80200003) : (l >> 1);
        return l;
    endfunction

    function automatic logic [DW-1:0] pat(input int b, input int k);
        int g = b * BB + k;
        logic [15:0] b16 = 16'(b), k16 = 16'(k);
        logic [31:0] l = lfsr_at(t_seed, g);
        logic [DW-1:0] one = 1;
        case (t_mode)
            2'd0:    return {b16, k16, b16, k16};
            2'd1:    return {l, ~l};
            2'd2:    return one << (g % DW);
            default: return (g % 2 == 1) ? {32{2'b10}} : {32{2'b01}};
        endcase
    endfunction

    // Controller model: captures write bursts into mem, returns read bursts LAT cycles after the command.
    int wcap = 0, wb = 0, rb = 0, rd_start = -1000, nb = 0, mk = 0;
    logic [AW-1:0] wa = '0, ra = '0, ea_m = '0;
    logic [DW-1:0] md = '0;
    initial forever begin
        @(negedge ext_clk);
        if (!rst_n) begin
            wcap = 0; rd_start = -1000; nb = 0; i_rd_data_valid = 1'b0;
        end else begin
            cyc++;
            if (cyc >= rd_start && cyc < rd_start + nb) begin
                mk = cyc - rd_start;
                md = mem[int'(ra) * BB + mk];
                if (f_corrupt && rb == 5 && mk == 2) md[3] = ~md[3];
                i_rd_data = md;
                i_rd_data_valid = 1'b1;
            end else begin
                i_rd_data = {$urandom, $urandom};
                i_rd_data_valid = 1'b0;
            end
            if (wcap > 0) begin
                mk = BB - wcap;
                chk("wr_data", o_wr_data, pat(wb, mk));
                mem[int'(wa) * BB + mk] = o_wr_data;
                wcap--;
            end
            if (o_cmd_en) begin
                if (!i_init_calib) nocal_cmd++;
                if (o_cmd) begin
                    wb = wcnt % NB; wa = o_addr;
                    ea_m = t_base + AW'(wb * STEP);
                    chk("wr_addr", o_addr, ea_m);
                    chk("wr_beat0", o_wr_data, pat(wb, 0));
                    mem[int'(wa) * BB] = o_wr_data;
                    wcap = BB - 1;
                    wcnt++;
                end else begin
                    rb = rcnt % NB; ra = o_addr;
                    ea_m = t_base + AW'(rb * STEP);
                    chk("rd_addr", o_addr, ea_m);
                    rd_start = cyc + LAT;
                    nb = f_novalid ? 0 : (f_short && rb == 0) ? BB - 1 : BB;
                    rcnt++;
                end
            end
        end
    end

    task automatic setup(input logic [1:0] m, input logic [31:0] s, input logic [AW-1:0] b);
        t_mode = m; t_seed = s; t_base = b;
        i_mode = m; i_seed = s; i_base_addr = b;
        f_corrupt = 0; f_novalid = 0; f_short = 0;
        wcnt = 0; rcnt = 0; nocal_cmd = 0;
    endtask

    task automatic pulse_start(input string tag);
        @(negedge ext_clk); i_start = 1'b1;
        @(negedge ext_clk); i_start = 1'b0;
        chk(tag, o_busy, 1);
    endtask

    task automatic wait_done(input int lim, input string tag);
        int n = 0;
        while (!o_done && n < lim) begin @(negedge ext_clk); n++; end
        chk(tag, o_done, 1);
        chk({tag, "_busy"}, o_busy, 0);
    endtask

    logic [AW-1:0] ea;
    int exp_pc = 0, n = 0, nb_busy = 0;

    initial begin
        repeat (3) @(negedge ext_clk);
        chk("rst_cmd_en", o_cmd_en, 0);
        chk("rst_busy", o_busy, 0);
        @(negedge ext_clk); #1 rst_n = 1'b1;
        repeat (2) @(negedge ext_clk);
        chk("idle_done", o_done, 0);
        chk("idle_pass", o_pass, 0);
        chk("idle_err", o_err_count, 0);
        chk("idle_pc", o_pass_count, 0);
        chk("idle_addr", o_addr, 0);
        chk("idle_wdata", o_wr_data, 0);

        // Mode 0 clean run
        setup(2'd0, $urandom, AW'($urandom));
        i_init_calib = 1'b1;
        pulse_start("t1_busy");
        wait_done(5000, "t1_done"); exp_pc++;
        chk("t1_pass", o_pass, 1);
        chk("t1_err", o_err_count, 0);
        chk("t1_tmo", o_timeout, 0);
        chk("t1_pc", o_pass_count, 16'(exp_pc));
        chk("t1_wcmds", wcnt, NB);
        chk("t1_rcmds", rcnt, NB);

        // Mode 1, seed 0, single-bit corruption in burst 5 beat 2
        setup(2'd1, 32'd0, AW'($urandom));
        f_corrupt = 1;
        pulse_start("t2_busy");
        wait_done(5000, "t2_done"); exp_pc++;
        ea = t_base + AW'(80);
        chk("t2_err", o_err_count, 1);
        chk("t2_faddr", o_first_err_addr, ea);
        chk("t2_fbeat", o_first_err_beat, 2);
        chk("t2_pass", o_pass, 0);
        chk("t2_pc", o_pass_count, 16'(exp_pc));

        // No read data ever returns
        setup(2'd3, $urandom, AW'($urandom));
        f_novalid = 1;
        pulse_start("t3_busy");
        wait_done(10000, "t3_done"); exp_pc++;
        chk("t3_tmo", o_timeout, 1);
        chk("t3_pass", o_pass, 0);
        chk("t3_err", o_err_count, 0);
        chk("t3_rcmds", rcnt, NB);

        // Burst 0 returns only 3 beats; LFSR data must stay aligned afterwards
        setup(2'd1, $urandom, AW'($urandom));
        f_short = 1;
        pulse_start("t4_busy");
        wait_done(5000, "t4_done"); exp_pc++;
        chk("t4_err", o_err_count, 1);
        chk("t4_tmo", o_timeout, 0);
        chk("t4_pass", o_pass, 0);
        chk("t4_faddr", o_first_err_addr, 0);

        // Calibration held off; address range wraps past 2^AW
        setup(2'd2, $urandom, 21'h1FFF80);
        i_init_calib = 1'b0;
        pulse_start("t5_busy");
        nb_busy = 0;
        repeat (1000) begin @(negedge ext_clk); if (!o_busy) nb_busy++; end
        chk("t5_busy_hold", nb_busy, 0);
        chk("t5_no_cmd", wcnt + rcnt, 0);
        i_init_calib = 1'b1;
        wait_done(5000, "t5_done"); exp_pc++;
        chk("t5_nocal_cmd", nocal_cmd, 0);
        chk("t5_pass", o_pass, 1);
        chk("t5_pc", o_pass_count, 16'(exp_pc));

        // Looping run, reset mid-write of the third pass
        setup(2'd3, $urandom, AW'($urandom));
        i_loop = 1'b1;
        pulse_start("t6_busy");
        n = 0;
        while (o_pass_count != 16'(exp_pc + 2) && n < 5000) begin @(negedge ext_clk); n++; end
        chk("t6_pc2", o_pass_count, 16'(exp_pc + 2));
        chk("t6_not_done", o_done, 0);
        chk("t6_err", o_err_count, 0);
        pulse_start("t6_start_ignored");
        chk("t6_still_not_done", o_done, 0);
        n = 0;
        while (!(o_cmd_en && wcnt >= 2 * NB + 5) && n < 2000) begin @(negedge ext_clk); n++; end
        chk("t6_mid_write_cmd", o_cmd_en, 1);
        #1 rst_n = 1'b0;
        #1;
        chk("t6_async_cmd_en", o_cmd_en, 0);
        chk("t6_rst_busy", o_busy, 0);
        chk("t6_rst_pc", o_pass_count, 0);
        chk("t6_rst_err", o_err_count, 0);
        chk("t6_rst_addr", o_addr, 0);
        chk("t6_rst_wdata", o_wr_data, 0);
        i_loop = 1'b0;
        @(negedge ext_clk); #1 rst_n = 1'b1;
        exp_pc = 0;

        // Clean run after reset
        setup(2'd0, $urandom, AW'($urandom));
        pulse_start("t7_busy");
        wait_done(5000, "t7_done"); exp_pc++;
        chk("t7_pass", o_pass, 1);
        chk("t7_pc", o_pass_count, 16'(exp_pc));
        chk("t7_wcmds", wcnt, NB);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
